alu_arbiter: RTL

//   Shares one ALU instance between two requesters (0 and 1). Arbitrates

---
 rtl/alu_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one pipelined ALU between two requesters.
// One operation is in flight at a time. Its result is returned on a
// valid/ready channel and tagged with the id of the requester that issued it.
module alu_arbiter #(
  parameter int BITS    = 8,
  parameter int ALU_LAT = 2,
  parameter int CNT_W   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [BITS-1:0]  i_req0_a,
  input  logic [BITS-1:0]  i_req0_b,
  input  logic [1:0]       i_req0_op,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [BITS-1:0]  i_req1_a,
  input  logic [BITS-1:0]  i_req1_b,
  input  logic [1:0]       i_req1_op,
  output logic [BITS-1:0]  o_alu_a,
  output logic [BITS-1:0]  o_alu_b,
  output logic [1:0]       o_alu_op,
  input  logic [BITS-1:0]  i_alu_out,
  input  logic [3:0]       i_alu_status,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic             o_rsp_id,
  output logic [BITS-1:0]  o_rsp_out,
  output logic [3:0]       o_rsp_status,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam int LAT_W = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               last_q;
  logic [LAT_W-1:0]   cnt_q;
  logic               grant;
  logic               accept;
  logic               capture;
  logic               deliver;

  // On a tie the requester that was not granted last time wins.
  // last_q resets to 1 so that requester 0 wins the first tie.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no latch is inferred.
    state_d      = state_q;
    grant        = 1'b0;
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    capture      = 1'b0;
    deliver      = 1'b0;

    if (i_req0_valid && i_req1_valid) begin
      grant = ~last_q;
    end else begin
      grant = i_req1_valid;
    end

    case (state_q)
      S_IDLE: begin
        if (i_rst && (i_req0_valid || i_req1_valid)) begin
          o_req0_ready = ~grant;
          o_req1_ready = grant;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == LAT_W'(1)) begin
          capture = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          deliver = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = o_req0_ready | o_req1_ready;
  assign o_busy = (state_q != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand issue, arbitration history and the latency counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_alu_a  <= '0;
      o_alu_b  <= '0;
      o_alu_op <= '0;
      o_rsp_id <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
    end else if (accept) begin
      o_alu_a  <= grant ? i_req1_a  : i_req0_a;
      o_alu_b  <= grant ? i_req1_b  : i_req0_b;
      o_alu_op <= grant ? i_req1_op : i_req0_op;
      o_rsp_id <= grant;
      last_q   <= grant;
      cnt_q    <= LAT_W'(ALU_LAT);
    end else if (state_q == S_WAIT) begin
      cnt_q <= cnt_q - LAT_W'(1);
    end
  end

  // Response capture, hold, and the saturating error counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_rsp_valid  <= 1'b0;
      o_rsp_out    <= '0;
      o_rsp_status <= '0;
      o_err_cnt    <= '0;
    end else begin
      if (capture) begin
        o_rsp_valid  <= 1'b1;
        o_rsp_out    <= i_alu_out;
        o_rsp_status <= i_alu_status;
      end else if (deliver) begin
        o_rsp_valid <= 1'b0;
      end

      if (deliver && o_rsp_status[0] && (o_err_cnt != {CNT_W{1'b1}})) begin
        o_err_cnt <= o_err_cnt + CNT_W'(1);
      end
    end
  end

endmodule
